// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, field indices, op encodings and helpers for the M-mode CSR file.
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MEIE     = 11;

    typedef enum logic [2:0] {
        OP_RW  = 3'b001,
        OP_RS  = 3'b010,
        OP_RC  = 3'b011,
        OP_RWI = 3'b101,
        OP_RSI = 3'b110,
        OP_RCI = 3'b111
    } csr_op_t;

    typedef enum logic {RUN, SLEEP} wfi_state_t;

    // funct3[1:0] selects write/set/clear; the immediate forms share the same ALU
    function automatic logic [31:0] csr_alu(input logic [1:0] op, input logic [31:0] old, input logic [31:0] src);
        return op == 2'b01 ? src : op == 2'b10 ? (old | src) : op == 2'b11 ? (old & ~src) : old;
    endfunction
endpackage

// File: rtl/csr_if.sv
// csr_if: EX-stage CSR/trap signals between the pipeline (master) and the CSR file (slave).
interface csr_if;
    logic        csr_en;
    logic [11:0] csr_addr;
    logic [2:0]  csr_funct3;
    logic [4:0]  csr_rs1_idx;
    logic [31:0] rs1_data;
    logic        mret;
    logic        wfi;
    logic        ext_irq;
    logic [31:0] resume_pc;
    logic        instr_retire;
    logic        stall;
    logic [31:0] csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        wfi_stall;

    modport master (
        output csr_en, csr_addr, csr_funct3, csr_rs1_idx, rs1_data, mret, wfi,
               ext_irq, resume_pc, instr_retire, stall,
        input  csr_rdata, redirect, redirect_pc, wfi_stall
    );

    modport slave (
        input  csr_en, csr_addr, csr_funct3, csr_rs1_idx, rs1_data, mret, wfi,
               ext_irq, resume_pc, instr_retire, stall,
        output csr_rdata, redirect, redirect_pc, wfi_stall
    );
endinterface

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter with increment enable and per-half writes that take priority over counting.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (wr_lo || wr_hi)
            cnt <= {wr_hi ? wdata : cnt[63:32], wr_lo ? wdata : cnt[31:0]};
        else if (inc)
            cnt <= cnt + 64'd1;
    end
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSRs, cycle/instret counters, interrupt entry, MRET and WFI sleep for the EX stage.
module csr_file #(
    parameter logic [31:0] MTVEC_RST = 32'h0001_0000
) (
    input logic  clk,
    input logic  rst,
    csr_if.slave bus
);
    import csr_pkg::*;

    logic        mstatus_mie, mstatus_mpie, mie_meie;
    logic [31:0] mtvec, mepc;
    logic [63:0] mcycle, minstret;
    wfi_state_t  state, state_nxt;
    csr_op_t     op;
    logic        irq_pending, irq_take, mret_take, wake, csr_we;
    logic [31:0] src, rdata, wdata;

    assign op          = csr_op_t'(bus.csr_funct3);
    assign irq_pending = mstatus_mie & mie_meie & bus.ext_irq;
    assign irq_take    = irq_pending & ~bus.stall;
    assign mret_take   = bus.mret & ~bus.stall & ~irq_take;
    assign wake        = mie_meie & bus.ext_irq;
    assign src         = bus.csr_funct3[2] ? {27'b0, bus.csr_rs1_idx} : rs1_sel();
    assign wdata       = csr_alu(bus.csr_funct3[1:0], rdata, src);

    function automatic logic [31:0] rs1_sel();
        return bus.rs1_data;
    endfunction

    // set/clear with rs1/zimm == 0 is a pure read
    assign csr_we = bus.csr_en & ~bus.stall & ~irq_take &
                    ((op == OP_RW || op == OP_RWI) ||
                     ((op == OP_RS || op == OP_RC || op == OP_RSI || op == OP_RCI) && bus.csr_rs1_idx != 5'd0));

    always_comb begin
        rdata = '0;
        case (bus.csr_addr)
            CSR_MSTATUS:                rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            CSR_MIE:                    rdata = {20'b0, mie_meie, 11'b0};
            CSR_MIP:                    rdata = {20'b0, bus.ext_irq, 11'b0};
            CSR_MTVEC:                  rdata = mtvec;
            CSR_MEPC:                   rdata = mepc;
            CSR_MCYCLE, CSR_CYCLE:      rdata = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:    rdata = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:  rdata = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[63:32];
            default:                    rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mtvec        <= {MTVEC_RST[31:2], 2'b00};
            mepc         <= '0;
        end else begin
            if (irq_take) begin
                mepc         <= {bus.resume_pc[31:2], 2'b00};
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_take) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (csr_we && bus.csr_addr == CSR_MSTATUS) begin
                mstatus_mie  <= wdata[MSTATUS_MIE];
                mstatus_mpie <= wdata[MSTATUS_MPIE];
            end
            if (csr_we && bus.csr_addr == CSR_MIE)
                mie_meie <= wdata[MIE_MEIE];
            if (csr_we && bus.csr_addr == CSR_MTVEC)
                mtvec <= {wdata[31:2], 2'b00};
            if (csr_we && bus.csr_addr == CSR_MEPC)
                mepc <= {wdata[31:2], 2'b00};
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (csr_we && bus.csr_addr == CSR_MCYCLE),
        .wr_hi (csr_we && bus.csr_addr == CSR_MCYCLEH),
        .wdata (wdata),
        .cnt   (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.instr_retire),
        .wr_lo (csr_we && bus.csr_addr == CSR_MINSTRET),
        .wr_hi (csr_we && bus.csr_addr == CSR_MINSTRETH),
        .wdata (wdata),
        .cnt   (minstret)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // wake ignores the global MIE so WFI works with interrupts masked
    always_comb begin
        state_nxt     = state;
        state_nxt     = state == RUN ? ((bus.wfi && !bus.stall && !irq_pending) ? SLEEP : RUN)
                                     : (wake ? RUN : SLEEP);
        bus.wfi_stall = state == SLEEP && !wake;
    end

    assign bus.csr_rdata   = rdata;
    assign bus.redirect    = irq_take | mret_take;
    assign bus.redirect_pc = irq_take ? mtvec : mepc;
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed-vector bench for csr_file with hand-computed expectations.
module tb_csr_file;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    csr_if bus ();

    csr_file #(.MTVEC_RST(32'h0001_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        bus.csr_addr = a;
        #1;
        chk(tag, bus.csr_rdata, exp);
    endtask

    task automatic op(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] idx, input logic [31:0] d);
        bus.csr_addr    = a;
        bus.csr_funct3  = f3;
        bus.csr_rs1_idx = idx;
        bus.rs1_data    = d;
        bus.csr_en      = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.csr_en = 0; bus.csr_addr = 0; bus.csr_funct3 = 0; bus.csr_rs1_idx = 0;
        bus.rs1_data = 0; bus.mret = 0; bus.wfi = 0; bus.ext_irq = 0;
        bus.resume_pc = 0; bus.instr_retire = 0; bus.stall = 0;
        tick(); tick();
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mie", 12'h304, 32'h0);
        rd("rst_mtvec", 12'h305, 32'h0001_0000);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mcycle", 12'hB00, 32'h0);
        chk("rst_redirect", {31'b0, bus.redirect}, 32'h0);
        chk("rst_wfi_stall", {31'b0, bus.wfi_stall}, 32'h0);
        rst = 1'b0;
        tick();

        op(12'h305, 3'b001, 5'd1, 32'h0002_0003);
        #1 chk("rw_mtvec_old", bus.csr_rdata, 32'h0001_0000);
        tick(); bus.csr_en = 0;
        rd("rw_mtvec_new", 12'h305, 32'h0002_0000);

        op(12'h304, 3'b001, 5'd1, 32'h0000_0800);
        tick(); bus.csr_en = 0;
        rd("mie_set", 12'h304, 32'h0000_0800);
        op(12'h304, 3'b011, 5'd0, 32'h0000_0800);
        tick(); bus.csr_en = 0;
        rd("rc_x0_nowrite", 12'h304, 32'h0000_0800);
        op(12'h304, 3'b110, 5'd0, 32'h0);
        tick(); bus.csr_en = 0;
        rd("rsi_zimm0_nowrite", 12'h304, 32'h0000_0800);

        op(12'h300, 3'b110, 5'd8, 32'h0);
        #1 chk("rsi_mstatus_old", bus.csr_rdata, 32'h0000_1800);
        tick(); bus.csr_en = 0;
        rd("rsi_mstatus_new", 12'h300, 32'h0000_1808);

        bus.resume_pc = 32'h0000_0107;
        bus.ext_irq = 1'b1;
        #1;
        chk("irq_redirect", {31'b0, bus.redirect}, 32'h1);
        chk("irq_redirect_pc", bus.redirect_pc, 32'h0002_0000);
        rd("mip_meip", 12'h344, 32'h0000_0800);
        tick(); bus.ext_irq = 1'b0;
        rd("irq_mepc", 12'h341, 32'h0000_0104);
        rd("irq_mstatus", 12'h300, 32'h0000_1880);
        chk("irq_redirect_off", {31'b0, bus.redirect}, 32'h0);

        bus.mret = 1'b1;
        #1;
        chk("mret_redirect", {31'b0, bus.redirect}, 32'h1);
        chk("mret_redirect_pc", bus.redirect_pc, 32'h0000_0104);
        tick(); bus.mret = 1'b0;
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        bus.resume_pc = 32'h0000_0200;
        bus.ext_irq = 1'b1;
        op(12'h304, 3'b001, 5'd1, 32'h0);
        #1 chk("coll_redirect", {31'b0, bus.redirect}, 32'h1);
        tick(); bus.csr_en = 0; bus.ext_irq = 1'b0;
        rd("coll_mie_kept", 12'h304, 32'h0000_0800);
        rd("coll_mepc", 12'h341, 32'h0000_0200);
        rd("coll_mstatus", 12'h300, 32'h0000_1880);

        bus.wfi = 1'b1; bus.stall = 1'b1;
        tick(); bus.wfi = 1'b0; bus.stall = 1'b0;
        #1 chk("wfi_stalled_nosleep", {31'b0, bus.wfi_stall}, 32'h0);
        bus.wfi = 1'b1;
        #1 chk("wfi_issue_cycle", {31'b0, bus.wfi_stall}, 32'h0);
        tick(); bus.wfi = 1'b0;
        #1 chk("wfi_sleep", {31'b0, bus.wfi_stall}, 32'h1);
        tick();
        #1 chk("wfi_still_sleep", {31'b0, bus.wfi_stall}, 32'h1);
        bus.ext_irq = 1'b1;
        #1;
        chk("wfi_wake_comb", {31'b0, bus.wfi_stall}, 32'h0);
        chk("wfi_wake_noredir", {31'b0, bus.redirect}, 32'h0);
        tick(); bus.ext_irq = 1'b0;
        #1 chk("wfi_run", {31'b0, bus.wfi_stall}, 32'h0);

        op(12'hB00, 3'b001, 5'd1, 32'hFFFF_FFFF);
        tick();
        op(12'hB80, 3'b001, 5'd1, 32'h0);
        tick(); bus.csr_en = 0;
        rd("cyc_lo_held", 12'hB00, 32'hFFFF_FFFF);
        rd("cyc_hi_written", 12'hB80, 32'h0);
        tick();
        rd("cyc_wrap_lo", 12'hB00, 32'h0);
        rd("cyc_wrap_hi", 12'hB80, 32'h1);
        rd("cycleh_mirror", 12'hC80, 32'h1);
        tick();
        rd("cycle_mirror", 12'hC00, 32'h1);

        op(12'hB02, 3'b001, 5'd1, 32'd5);
        bus.instr_retire = 1'b1;
        tick(); bus.csr_en = 0;
        tick(); tick(); bus.instr_retire = 1'b0;
        rd("minstret", 12'hB02, 32'd7);
        rd("instret_mirror", 12'hC02, 32'd7);
        rd("minstreth", 12'hB82, 32'h0);
        op(12'hC02, 3'b001, 5'd1, 32'h0);
        tick(); bus.csr_en = 0;
        rd("instret_ro", 12'hC02, 32'd7);
        op(12'h7C0, 3'b001, 5'd1, 32'h0000_FFFF);
        tick(); bus.csr_en = 0;
        rd("unimpl_zero", 12'h7C0, 32'h0);

        bus.wfi = 1'b1;
        tick(); bus.wfi = 1'b0; bus.stall = 1'b1;
        #1 chk("pre_rst_sleep", {31'b0, bus.wfi_stall}, 32'h1);
        rst = 1'b1;
        tick();
        chk("rst2_wfi_stall", {31'b0, bus.wfi_stall}, 32'h0);
        rd("rst2_mstatus", 12'h300, 32'h0000_1800);
        rd("rst2_mie", 12'h304, 32'h0);
        rd("rst2_mtvec", 12'h305, 32'h0001_0000);
        rd("rst2_mepc", 12'h341, 32'h0);
        rd("rst2_mcycleh", 12'hB80, 32'h0);
        rd("rst2_minstret", 12'hB02, 32'h0);
        rst = 1'b0; bus.stall = 1'b0;
        tick();
        chk("rst2_run", {31'b0, bus.wfi_stall}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
